// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle control sequencer: fetch (T0-T2), decode at T3, execute up to T7.
// Outputs are decoded from the registered step; only the memory-wait MDRin follows mem_ready.
module cpu_control_unit #(
  parameter int unsigned TIMEOUT_EN = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRread,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Yout,
  output logic        Cout,
  output logic        Zin,
  output logic        ZLowSelect,
  output logic        ZHighSelect,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic        HIout,
  output logic        Loout,
  output logic [4:0]  ALU_opcode,
  output logic        mem_read,
  output logic        mem_write,
  output logic        run,
  output logic        fault
);

  localparam logic [3:0] ST_T0   = 4'd0;
  localparam logic [3:0] ST_T1   = 4'd1;
  localparam logic [3:0] ST_T2   = 4'd2;
  localparam logic [3:0] ST_T3   = 4'd3;
  localparam logic [3:0] ST_T4   = 4'd4;
  localparam logic [3:0] ST_T5   = 4'd5;
  localparam logic [3:0] ST_T6   = 4'd6;
  localparam logic [3:0] ST_T7   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam logic [2:0] CL_NOP    = 3'd0;
  localparam logic [2:0] CL_ALU    = 3'd1;
  localparam logic [2:0] CL_MULDIV = 3'd2;
  localparam logic [2:0] CL_ADDI   = 3'd3;
  localparam logic [2:0] CL_LDI    = 3'd4;
  localparam logic [2:0] CL_LD     = 3'd5;
  localparam logic [2:0] CL_ST     = 3'd6;
  localparam logic [2:0] CL_HALT   = 3'd7;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  logic [3:0]  r_state, w_next, w_done;
  logic        r_stop, r_fault;
  logic [7:0]  r_wait_cnt;
  logic [2:0]  w_class;
  logic        w_wait, w_timeout;
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic [15:0] w_oh_ra, w_oh_rb, w_oh_rc, w_base_rb;
  logic        w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir[14:0];
  assign w_oh_ra     = 16'h0001 << w_ra;
  assign w_oh_rb     = 16'h0001 << w_rb;
  assign w_oh_rc     = 16'h0001 << w_rc;
  // R0 as an address/immediate base leaves the bus undriven, i.e. zero.
  assign w_base_rb   = (w_rb == 4'd0) ? 16'h0000 : w_oh_rb;

  always_comb begin
    case (w_op)
      5'b00000:                            w_class = CL_LD;
      5'b00001:                            w_class = CL_LDI;
      5'b00010:                            w_class = CL_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: w_class = CL_ALU;
      5'b01100:                            w_class = CL_ADDI;
      5'b01111, 5'b10000:                  w_class = CL_MULDIV;
      5'b11011:                            w_class = CL_HALT;
      default:                             w_class = CL_NOP;
    endcase
  end

  assign w_wait    = (r_state == ST_T1) ||
                     ((r_state == ST_T6) && (w_class == CL_LD)) ||
                     ((r_state == ST_T7) && (w_class == CL_ST));
  assign w_timeout = (TIMEOUT_EN != 0) && w_wait && !mem_ready && (r_wait_cnt == 8'd254);
  assign w_done    = (r_stop || stop) ? ST_HALT : ST_T0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_T0: w_next = ST_T1;
      ST_T1: w_next = mem_ready ? ST_T2 : ST_T1;
      ST_T2: w_next = ST_T3;
      ST_T3: begin
        case (w_class)
          CL_NOP, CL_LDI: w_next = w_done;
          CL_HALT:        w_next = ST_HALT;
          default:        w_next = ST_T4;
        endcase
      end
      ST_T4: w_next = ST_T5;
      ST_T5: w_next = ((w_class == CL_ALU) || (w_class == CL_ADDI)) ? w_done : ST_T6;
      ST_T6: begin
        case (w_class)
          CL_LD:   w_next = mem_ready ? ST_T7 : ST_T6;
          CL_ST:   w_next = ST_T7;
          default: w_next = w_done;
        endcase
      end
      ST_T7: w_next = ((w_class == CL_ST) && !mem_ready) ? ST_T7 : w_done;
      default: w_next = ST_HALT;
    endcase
    if (w_timeout) w_next = ST_HALT;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= ST_T0;
      r_stop     <= 1'b0;
      r_fault    <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_stop     <= r_stop | stop;
      r_fault    <= r_fault | w_timeout;
      r_wait_cnt <= (w_wait && !mem_ready) ? r_wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    Rin = 16'h0000; Rout = 16'h0000; ALU_opcode = 5'b00000;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRread = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Yout = 1'b0;
    Cout = 1'b0; Zin = 1'b0; ZLowSelect = 1'b0; ZHighSelect = 1'b0; ZLOout = 1'b0;
    ZHIout = 1'b0; HIin = 1'b0; Loin = 1'b0; HIout = 1'b0; Loout = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    fault = r_fault;
    run = (r_state != ST_HALT) || !clr;
    if (clr) begin
      case (r_state)
        ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
        ST_T1: begin mem_read = 1'b1; MDRread = 1'b1; MDRin = mem_ready; end
        ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        ST_T3: begin
          case (w_class)
            CL_ALU:              begin Rout = w_oh_rb; Yin = 1'b1; end
            CL_ADDI, CL_LD, CL_ST: begin Rout = w_base_rb; Yin = 1'b1; end
            CL_MULDIV:           begin Rout = w_oh_ra; Yin = 1'b1; end
            CL_LDI:              begin Cout = 1'b1; Rin = w_oh_ra; end
            default: ;
          endcase
        end
        ST_T4: begin
          Zin = 1'b1;
          case (w_class)
            CL_ALU:    begin Rout = w_oh_rc; ALU_opcode = w_op; end
            CL_MULDIV: begin Rout = w_oh_rb; ALU_opcode = w_op; end
            default:   begin Cout = 1'b1; ALU_opcode = ALU_ADD; end
          endcase
        end
        ST_T5: begin
          ZLowSelect = 1'b1;
          ZLOout     = 1'b1;
          case (w_class)
            CL_MULDIV:    Loin = 1'b1;
            CL_LD, CL_ST: MARin = 1'b1;
            default:      Rin = w_oh_ra;
          endcase
        end
        ST_T6: begin
          case (w_class)
            CL_LD:   begin mem_read = 1'b1; MDRread = 1'b1; MDRin = mem_ready; end
            CL_ST:   begin Rout = w_oh_ra; MDRin = 1'b1; end
            default: begin ZHighSelect = 1'b1; ZHIout = 1'b1; HIin = 1'b1; end
          endcase
        end
        ST_T7: begin
          if (w_class == CL_ST) begin
            mem_write = 1'b1;
          end else begin
            MDRout = 1'b1;
            Rin    = w_oh_ra;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: random and directed instruction streams checked cycle by cycle
// against a per-instruction step list derived from the instruction semantics.
module tb_cpu_control_unit;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcout, pcin, incpc, marin, mdrin, mdrread, mdrout, irin, yin, yout, cout, zin;
    logic zlowsel, zhighsel, zloout, zhiout, hiin, loin, hiout, loout;
    logic [4:0] alu;
    logic mem_read, mem_write, run, fault;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          w1;
    int          w2;
    int          stop_at;
  } stim_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        mem_ready, stop;
  logic [15:0] Rin, Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Yout, Cout, Zin;
  logic ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, HIout, Loout;
  logic [4:0] ALU_opcode;
  logic mem_read, mem_write, run, fault;
  obs_t dut_obs;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t exp_q[$];
  bit   wt_q[$];

  always #5 clk = ~clk;

  cpu_control_unit #(.TIMEOUT_EN(1)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Yout(Yout),
    .Cout(Cout), .Zin(Zin), .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .Loin(Loin), .HIout(HIout), .Loout(Loout),
    .ALU_opcode(ALU_opcode), .mem_read(mem_read), .mem_write(mem_write), .run(run),
    .fault(fault)
  );

  assign dut_obs = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin,
                    Yout, Cout, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, HIout,
                    Loout, ALU_opcode, mem_read, mem_write, run, fault};

  function automatic obs_t blank();
    obs_t e;
    e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic obs_t fetch_t0();
    obs_t e;
    e = blank();
    e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] sel(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  // Step list: operand A -> Y, operand B combined in Z, result written back, then memory phase.
  task automatic build_model(input logic [31:0] i, output bit halts);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit   is_alu, is_md, is_imm;
    obs_t e;
    op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
    is_alu = (op >= 5'd3) && (op <= 5'd6);
    is_md  = (op == 5'd15) || (op == 5'd16);
    is_imm = (op == 5'd12) || (op == 5'd0) || (op == 5'd2);
    exp_q.delete(); wt_q.delete();
    halts = 1'b0;
    exp_q.push_back(fetch_t0()); wt_q.push_back(1'b0);
    e = blank(); e.mem_read = 1'b1; e.mdrread = 1'b1; e.mdrin = 1'b1;
    exp_q.push_back(e); wt_q.push_back(1'b1);
    e = blank(); e.mdrout = 1'b1; e.irin = 1'b1;
    exp_q.push_back(e); wt_q.push_back(1'b0);
    if (is_alu || is_md || is_imm) begin
      e = blank(); e.yin = 1'b1;
      e.rout = is_md ? sel(ra) : (is_imm && rb == 4'd0) ? 16'h0 : sel(rb);
      exp_q.push_back(e); wt_q.push_back(1'b0);
      e = blank(); e.zin = 1'b1;
      if (is_imm) begin e.cout = 1'b1; e.alu = 5'd3; end
      else begin e.rout = is_md ? sel(rb) : sel(rc); e.alu = op; end
      exp_q.push_back(e); wt_q.push_back(1'b0);
      e = blank(); e.zlowsel = 1'b1; e.zloout = 1'b1;
      if (is_md) e.loin = 1'b1;
      else if (op == 5'd0 || op == 5'd2) e.marin = 1'b1;
      else e.rin = sel(ra);
      exp_q.push_back(e); wt_q.push_back(1'b0);
      if (is_md) begin
        e = blank(); e.zhighsel = 1'b1; e.zhiout = 1'b1; e.hiin = 1'b1;
        exp_q.push_back(e); wt_q.push_back(1'b0);
      end else if (op == 5'd0) begin
        e = blank(); e.mem_read = 1'b1; e.mdrread = 1'b1; e.mdrin = 1'b1;
        exp_q.push_back(e); wt_q.push_back(1'b1);
        e = blank(); e.mdrout = 1'b1; e.rin = sel(ra);
        exp_q.push_back(e); wt_q.push_back(1'b0);
      end else if (op == 5'd2) begin
        e = blank(); e.rout = sel(ra); e.mdrin = 1'b1;
        exp_q.push_back(e); wt_q.push_back(1'b0);
        e = blank(); e.mem_write = 1'b1;
        exp_q.push_back(e); wt_q.push_back(1'b1);
      end
    end else if (op == 5'd1) begin
      e = blank(); e.cout = 1'b1; e.rin = sel(ra);
      exp_q.push_back(e); wt_q.push_back(1'b0);
    end else begin
      exp_q.push_back(blank()); wt_q.push_back(1'b0);
      halts = (op == 5'd27);
    end
  endtask

  // Leaves the DUT in T0 at the next falling edge.
  task automatic do_reset();
    mem_ready = 1'b0; stop = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #2 clr = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    do_reset();
    ir = 32'h1A238000; mem_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (dut_obs !== fetch_t0()) begin
      n_bad++; $display("FAIL reset_first_t0: got %h want %h", dut_obs, fetch_t0());
    end
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (Zin !== 1'b1 || Rout !== 16'h0080) begin
      n_bad++; $display("FAIL reach_t4: got Zin=%b Rout=%h want Zin=1 Rout=0080", Zin, Rout);
    end
    clr = 1'b0;
    #1;
    e = blank();
    n_cmp++;
    if (dut_obs !== e) begin
      n_bad++; $display("FAIL reset_mid_decode: got %h want %h", dut_obs, e);
    end
    @(posedge clk); #2;
    n_cmp++;
    if (dut_obs !== e) begin
      n_bad++; $display("FAIL reset_held: got %h want %h", dut_obs, e);
    end
    clr = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (dut_obs !== fetch_t0()) begin
      n_bad++; $display("FAIL post_reset_t0: got %h want %h", dut_obs, fetch_t0());
    end
  endtask

  task automatic test_instr_stream();
    stim_t prog[$];
    stim_t s;
    bit    halts;
    int    nth, nw, hold;
    logic [4:0] op;
    obs_t  e;
    prog.push_back('{32'h1A238000, 3, 0, -1});   // add R4,R4,R7, slow fetch
    prog.push_back('{32'h7A180000, 0, 0, -1});   // mul R4,R3
    prog.push_back('{32'h01080065, 0, 2, -1});   // ld R2,0x65(R1)
    prog.push_back('{32'h11080065, 1, 3, -1});   // st R2,0x65(R1)
    prog.push_back('{32'h01000010, 0, 0, -1});   // ld R2,0x10(R0)
    prog.push_back('{32'h60000000, 0, 0, -1});   // addi R0,R0,0
    prog.push_back('{32'hF8000000, 0, 0, -1});   // illegal -> nop
    prog.push_back('{32'hC0000000, 2, 0, -1});   // nop
    prog.push_back('{32'h0A800000, 0, 0, -1});   // ldi R5
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd24;
      s.ir = {op, 27'($urandom)};
      s.w1 = $urandom_range(0, 4); s.w2 = $urandom_range(0, 4); s.stop_at = -1;
      prog.push_back(s);
    end
    prog.push_back('{32'h61B00000, 0, 0, 4});    // addi R3,R6 with stop in T4
    prog.push_back('{32'hD8000000, 1, 0, -1});   // halt
    prog.push_back('{32'hD8000000, 0, 0, 3});    // halt with stop in the decode cycle
    do_reset();
    for (int p = 0; p < prog.size(); p++) begin
      build_model(prog[p].ir, halts);
      if (prog[p].stop_at >= 0) halts = 1'b1;
      nth = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        nw = 0;
        if (wt_q[k]) begin
          nw = (nth == 0) ? prog[p].w1 : prog[p].w2;
          nth++;
        end
        for (int c = 0; c <= nw; c++) begin
          @(negedge clk);
          ir = prog[p].ir;
          stop = (k == prog[p].stop_at) && (c == 0);
          mem_ready = wt_q[k] ? (c == nw) : 1'($urandom);
          #1;
          e = exp_q[k];
          if (wt_q[k] && e.mdrin) e.mdrin = (c == nw);
          n_cmp++;
          if (dut_obs !== e) begin
            n_bad++;
            $display("FAIL stream[%0d] ir=%h step %0d wait %0d: got %h want %h",
                     p, prog[p].ir, k, c, dut_obs, e);
          end
        end
      end
      stop = 1'b0;
      if (halts) begin
        e = '0;
        hold = (prog[p].stop_at < 0) ? 100 : 10;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          mem_ready = 1'($urandom);
          #1;
          n_cmp++;
          if (dut_obs !== e) begin
            n_bad++;
            $display("FAIL halted[%0d] cycle %0d: got %h want %h", p, h, dut_obs, e);
          end
        end
        do_reset();
      end
    end
  endtask

  task automatic test_timeout();
    int  waits;
    bit  done;
    obs_t e;
    do_reset();
    ir = 32'hC0000000;
    waits = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (!run) done = 1'b1;
      else if (mem_read) waits++;
    end
    n_cmp++;
    if (!done || waits != 255) begin
      n_bad++; $display("FAIL timeout_cycles: got halted=%0d after %0d waits want 1 after 255",
                        done, waits);
    end
    e = '0; e.fault = 1'b1;
    n_cmp++;
    if (dut_obs !== e) begin
      n_bad++; $display("FAIL timeout_fault: got %h want %h", dut_obs, e);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    n_cmp++;
    if (dut_obs !== e) begin
      n_bad++; $display("FAIL fault_sticky: got %h want %h", dut_obs, e);
    end
    do_reset();
    @(negedge clk); #1;
    n_cmp++;
    if (dut_obs !== fetch_t0()) begin
      n_bad++; $display("FAIL fault_cleared: got %h want %h", dut_obs, fetch_t0());
    end
  endtask

  initial begin
    clr = 1'b0; ir = 32'h0; mem_ready = 1'b0; stop = 1'b0;
    test_reset();
    test_instr_stream();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
